mem_ctrl: RTL and testbench

- Byte-serial memory controller between the CPU's two memory clients and the external 8-bit RAM/IO bus.
- Clients: instruction fetch (word reads) and the store/load buffer (byte/half/word reads and writes).
- Arbitrates between the clients, sequences multi-byte accesses over the 1-byte bus, assembles little-endian read data, and stalls IO writes while the UART buffer is full.
- Replaces the ad-hoc combinational muxing of mem_a/mem_wr in the CPU top.

---
 rtl/mem_ctrl_if.sv | 42 ++++
 rtl/mem_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_mem_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Client and byte-bus signal bundle for mem_ctrl.
// The controller takes the slave view; the CPU side and the RAM/IO bus take the master view.
interface mem_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  rdy_in;
    logic                  control_hazard;
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_done;
    logic [31:0]           if_data;
    logic                  lsb_req;
    logic                  lsb_wr;
    logic [ADDR_WIDTH-1:0] lsb_addr;
    logic [1:0]            lsb_len;
    logic [31:0]           lsb_wdata;
    logic                  lsb_done;
    logic [31:0]           lsb_rdata;
    logic [7:0]            mem_din;
    logic [7:0]            mem_dout;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic                  mem_wr;
    logic                  io_buffer_full;

    modport slave (
        input  rdy_in, control_hazard,
        input  if_req, if_addr,
        input  lsb_req, lsb_wr, lsb_addr, lsb_len, lsb_wdata,
        input  mem_din, io_buffer_full,
        output if_done, if_data, lsb_done, lsb_rdata,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output rdy_in, control_hazard,
        output if_req, if_addr,
        output lsb_req, lsb_wr, lsb_addr, lsb_len, lsb_wdata,
        output mem_din, io_buffer_full,
        input  if_done, if_data, lsb_done, lsb_rdata,
        input  mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch and load/store clients onto the
// 8-bit RAM/IO bus, assembling little-endian read data one byte per cycle.
module mem_ctrl #(
    parameter int         ADDR_WIDTH = 32,
    parameter logic [1:0] IO_SEL     = 2'b11
) (
    input  logic        clk_in,
    input  logic        rst_in,
    mem_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IF_RD = 3'd1,
        LS_RD = 3'd2,
        LS_WR = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [2:0]            len_q, len_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           data_q, data_d;
    logic                  owner_if_q, owner_if_d;
    logic                  issued_q, issued_d;

    logic [ADDR_WIDTH-1:0] cur_addr_s;
    logic                  io_stall_s;
    logic [1:0]            cap_idx_s;
    logic [7:0]            wbyte_s;

    function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
        case (len)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Current byte address, IO stall condition, capture slot and outgoing store byte.
    always_comb begin
        cur_addr_s = addr_q + ADDR_WIDTH'(idx_q);
        io_stall_s = (state_q == LS_WR) && (cur_addr_s[17:16] == IO_SEL) && bus.io_buffer_full;
        cap_idx_s  = idx_q[1:0] - 2'd1;
        wbyte_s    = 8'(wdata_q >> {idx_q[1:0], 3'b000});
    end

    // Next-state logic; issued_q marks that last cycle put a valid read address on the bus.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_d     = data_q;
        owner_if_d = owner_if_q;
        issued_d   = 1'b0;
        if (!bus.rdy_in) begin
            // The byte addressed last cycle is lost; step back so it is requested again.
            if (issued_q) begin
                idx_d = idx_q - 3'd1;
            end else begin
                idx_d = idx_q;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.lsb_req) begin
                        state_d    = bus.lsb_wr ? LS_WR : LS_RD;
                        addr_d     = bus.lsb_addr;
                        len_d      = len_to_bytes(bus.lsb_len);
                        wdata_d    = bus.lsb_wdata;
                        owner_if_d = 1'b0;
                        idx_d      = 3'd0;
                        data_d     = 32'd0;
                    end else if (bus.if_req && !bus.control_hazard) begin
                        state_d    = IF_RD;
                        addr_d     = bus.if_addr;
                        len_d      = 3'd4;
                        wdata_d    = 32'd0;
                        owner_if_d = 1'b1;
                        idx_d      = 3'd0;
                        data_d     = 32'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                IF_RD, LS_RD: begin
                    if ((state_q == IF_RD) && bus.control_hazard) begin
                        state_d = IDLE;
                        idx_d   = 3'd0;
                    end else begin
                        if (issued_q) begin
                            data_d[{cap_idx_s, 3'b000} +: 8] = bus.mem_din;
                        end else begin
                            data_d = data_q;
                        end
                        if (idx_q == len_q) begin
                            state_d = RESP;
                            idx_d   = 3'd0;
                        end else begin
                            idx_d    = idx_q + 3'd1;
                            issued_d = 1'b1;
                        end
                    end
                end
                LS_WR: begin
                    if (io_stall_s) begin
                        idx_d = idx_q;
                    end else if (idx_q == (len_q - 3'd1)) begin
                        state_d = RESP;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                RESP: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = 3'd0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            len_q      <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            data_q     <= 32'd0;
            owner_if_q <= 1'b0;
            issued_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_q     <= data_d;
            owner_if_q <= owner_if_d;
            issued_q   <= issued_d;
        end
    end

    // Bus and client outputs decoded from registered state; mem_wr is gated by ready and IO stall.
    always_comb begin
        bus.mem_a     = '0;
        bus.mem_dout  = 8'd0;
        bus.mem_wr    = 1'b0;
        bus.if_done   = 1'b0;
        bus.lsb_done  = 1'b0;
        bus.if_data   = 32'd0;
        bus.lsb_rdata = 32'd0;
        case (state_q)
            IF_RD, LS_RD: begin
                if (idx_q < len_q) begin
                    bus.mem_a = cur_addr_s;
                end else begin
                    bus.mem_a = '0;
                end
            end
            LS_WR: begin
                bus.mem_a    = cur_addr_s;
                bus.mem_dout = wbyte_s;
                bus.mem_wr   = bus.rdy_in && !io_stall_s;
            end
            RESP: begin
                if (owner_if_q) begin
                    bus.if_done = 1'b1;
                    bus.if_data = data_q;
                end else begin
                    bus.lsb_done  = 1'b1;
                    bus.lsb_rdata = data_q;
                end
            end
            default: begin
                bus.mem_a = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a registered byte-memory model on the bus.
module tb_mem_ctrl;

    logic clk_in = 1'b0;
    logic rst_in;
    int   vectors     = 0;
    int   miscompares = 0;

    mem_ctrl_if #(.ADDR_WIDTH(32)) bus ();

    mem_ctrl #(.ADDR_WIDTH(32), .IO_SEL(2'b11)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h0000_1000: mem_byte = 8'h13;
            32'h0000_1001: mem_byte = 8'h05;
            32'h0000_1002: mem_byte = 8'h00;
            32'h0000_1003: mem_byte = 8'h00;
            32'h0000_2000: mem_byte = 8'h78;
            32'h0000_2001: mem_byte = 8'h56;
            32'h0000_2002: mem_byte = 8'h34;
            32'h0000_2003: mem_byte = 8'h12;
            32'hFFFF_FFFF: mem_byte = 8'hC3;
            32'h0000_0000: mem_byte = 8'h3C;
            default:       mem_byte = 8'hEE;
        endcase
    endfunction

    // RAM returns the byte one cycle after its address.
    always @(posedge clk_in) bus.mem_din <= mem_byte(bus.mem_a);

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset;
        #1;
        vectors++;
        if (bus.mem_a !== 32'd0 || bus.mem_wr !== 1'b0 || bus.mem_dout !== 8'd0 ||
            bus.if_done !== 1'b0 || bus.lsb_done !== 1'b0 || bus.if_data !== 32'd0 || bus.lsb_rdata !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got a=%h wr=%b dout=%h ifd=%b lsd=%b ifdata=%h lsrdata=%h want all 0",
                     bus.mem_a, bus.mem_wr, bus.mem_dout, bus.if_done, bus.lsb_done, bus.if_data, bus.lsb_rdata);
        end
        tick(); tick();
        rst_in = 1'b0;
        tick();
    endtask

    task automatic test_fetch;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h1000;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (bus.mem_a !== 32'h1000 + 32'(i) || bus.mem_wr !== 1'b0) begin
                miscompares++;
                $display("FAIL fetch_addr[%0d] got a=%h wr=%b want a=%h wr=0", i, bus.mem_a, bus.mem_wr, 32'h1000 + 32'(i));
            end
        end
        tick();
        vectors++;
        if (bus.mem_a !== 32'd0 || bus.if_done !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_trail got a=%h done=%b want a=0 done=0", bus.mem_a, bus.if_done);
        end
        tick();
        vectors++;
        if (bus.if_done !== 1'b1 || bus.if_data !== 32'h0000_0513 || bus.lsb_done !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_done got done=%b data=%h lsd=%b want done=1 data=00000513 lsd=0", bus.if_done, bus.if_data, bus.lsb_done);
        end
        bus.if_req = 1'b0;
        tick();
        vectors++;
        if (bus.if_done !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_pulse got done=%b want 0", bus.if_done);
        end
    endtask

    task automatic test_priority;
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h1000;
        bus.lsb_req   = 1'b1;
        bus.lsb_wr    = 1'b0;
        bus.lsb_addr  = 32'h2000;
        bus.lsb_len   = 2'd2;
        tick();
        vectors++;
        if (bus.mem_a !== 32'h2000) begin
            miscompares++;
            $display("FAIL prio_first got a=%h want 00002000", bus.mem_a);
        end
        for (int i = 2; i <= 5; i++) begin
            tick();
            vectors++;
            if (bus.if_done !== 1'b0 || bus.lsb_done !== 1'b0) begin
                miscompares++;
                $display("FAIL prio_early_done[T+%0d] got ifd=%b lsd=%b want 0 0", i, bus.if_done, bus.lsb_done);
            end
        end
        tick();
        vectors++;
        if (bus.lsb_done !== 1'b1 || bus.lsb_rdata !== 32'h1234_5678 || bus.if_done !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_lsb_done got lsd=%b rdata=%h ifd=%b want 1 12345678 0", bus.lsb_done, bus.lsb_rdata, bus.if_done);
        end
        bus.lsb_req = 1'b0;
        tick();
        vectors++;
        if (bus.mem_a !== 32'd0 || bus.lsb_done !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_idle got a=%h lsd=%b want 0 0", bus.mem_a, bus.lsb_done);
        end
        tick();
        vectors++;
        if (bus.mem_a !== 32'h1000) begin
            miscompares++;
            $display("FAIL prio_fetch_start got a=%h want 00001000", bus.mem_a);
        end
        for (int i = 2; i <= 5; i++) tick();
        vectors++;
        if (bus.if_done !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_fetch_early got ifd=%b want 0", bus.if_done);
        end
        tick();
        vectors++;
        if (bus.if_done !== 1'b1 || bus.if_data !== 32'h0000_0513) begin
            miscompares++;
            $display("FAIL prio_fetch_done got ifd=%b data=%h want 1 00000513", bus.if_done, bus.if_data);
        end
        bus.if_req = 1'b0;
        tick();
    endtask

    task automatic test_io_stall;
        bus.lsb_req        = 1'b1;
        bus.lsb_wr         = 1'b1;
        bus.lsb_addr       = 32'h0003_0000;
        bus.lsb_len        = 2'd0;
        bus.lsb_wdata      = 32'h0000_0041;
        bus.io_buffer_full = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            vectors++;
            if (bus.mem_wr !== 1'b0 || bus.mem_a !== 32'h0003_0000) begin
                miscompares++;
                $display("FAIL io_stall[T+%0d] got wr=%b a=%h want wr=0 a=00030000", i, bus.mem_wr, bus.mem_a);
            end
        end
        tick();
        bus.io_buffer_full = 1'b0;
        #1;
        vectors++;
        if (bus.mem_wr !== 1'b1 || bus.mem_dout !== 8'h41 || bus.mem_a !== 32'h0003_0000) begin
            miscompares++;
            $display("FAIL io_issue got wr=%b dout=%h a=%h want 1 41 00030000", bus.mem_wr, bus.mem_dout, bus.mem_a);
        end
        tick();
        vectors++;
        if (bus.lsb_done !== 1'b1 || bus.mem_wr !== 1'b0 || bus.lsb_rdata !== 32'd0) begin
            miscompares++;
            $display("FAIL io_done got lsd=%b wr=%b rdata=%h want 1 0 0", bus.lsb_done, bus.mem_wr, bus.lsb_rdata);
        end
        bus.lsb_req = 1'b0;
        tick();
    endtask

    task automatic test_hazard;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h1000;
        tick();
        vectors++;
        if (bus.mem_a !== 32'h1000) begin
            miscompares++;
            $display("FAIL hz_start got a=%h want 00001000", bus.mem_a);
        end
        tick();
        bus.control_hazard = 1'b1;
        bus.if_req         = 1'b0;
        tick();
        bus.control_hazard = 1'b0;
        vectors++;
        if (bus.mem_a !== 32'd0) begin
            miscompares++;
            $display("FAIL hz_abort got a=%h want 0", bus.mem_a);
        end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (bus.if_done !== 1'b0 || bus.mem_wr !== 1'b0) begin
                miscompares++;
                $display("FAIL hz_quiet[%0d] got ifd=%b wr=%b want 0 0", i, bus.if_done, bus.mem_wr);
            end
            tick();
        end
        // A fetch request seen together with the flush in IDLE is dropped.
        bus.if_req         = 1'b1;
        bus.control_hazard = 1'b1;
        tick();
        bus.if_req         = 1'b0;
        bus.control_hazard = 1'b0;
        vectors++;
        if (bus.mem_a !== 32'd0) begin
            miscompares++;
            $display("FAIL hz_idle_drop got a=%h want 0", bus.mem_a);
        end
        tick();
        bus.lsb_req  = 1'b1;
        bus.lsb_wr   = 1'b0;
        bus.lsb_addr = 32'h2001;
        bus.lsb_len  = 2'd0;
        tick();
        bus.control_hazard = 1'b1;
        vectors++;
        if (bus.mem_a !== 32'h2001) begin
            miscompares++;
            $display("FAIL hz_ls_start got a=%h want 00002001", bus.mem_a);
        end
        tick();
        tick();
        bus.control_hazard = 1'b0;
        vectors++;
        if (bus.lsb_done !== 1'b1 || bus.lsb_rdata !== 32'h0000_0056) begin
            miscompares++;
            $display("FAIL hz_ls_done got lsd=%b rdata=%h want 1 00000056", bus.lsb_done, bus.lsb_rdata);
        end
        bus.lsb_req = 1'b0;
        tick();
    endtask

    task automatic test_rdy_write;
        bus.lsb_req        = 1'b1;
        bus.lsb_wr         = 1'b1;
        bus.lsb_addr       = 32'h0FFF;
        bus.lsb_len        = 2'd1;
        bus.lsb_wdata      = 32'h0000_BEEF;
        bus.io_buffer_full = 1'b1;
        tick();
        vectors++;
        if (bus.mem_a !== 32'h0FFF || bus.mem_dout !== 8'hEF || bus.mem_wr !== 1'b1) begin
            miscompares++;
            $display("FAIL rdyw_b0 got a=%h dout=%h wr=%b want 00000fff ef 1", bus.mem_a, bus.mem_dout, bus.mem_wr);
        end
        tick();
        bus.rdy_in = 1'b0;
        #1;
        vectors++;
        if (bus.mem_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL rdyw_hold got wr=%b want 0", bus.mem_wr);
        end
        tick();
        bus.rdy_in = 1'b1;
        #1;
        vectors++;
        if (bus.mem_a !== 32'h1000 || bus.mem_dout !== 8'hBE || bus.mem_wr !== 1'b1) begin
            miscompares++;
            $display("FAIL rdyw_b1 got a=%h dout=%h wr=%b want 00001000 be 1", bus.mem_a, bus.mem_dout, bus.mem_wr);
        end
        tick();
        vectors++;
        if (bus.lsb_done !== 1'b1 || bus.lsb_rdata !== 32'd0 || bus.mem_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL rdyw_done got lsd=%b rdata=%h wr=%b want 1 0 0", bus.lsb_done, bus.lsb_rdata, bus.mem_wr);
        end
        bus.lsb_req        = 1'b0;
        bus.io_buffer_full = 1'b0;
        tick();
    endtask

    task automatic test_rdy_read;
        logic [31:0] exp_a;
        bus.lsb_req  = 1'b1;
        bus.lsb_wr   = 1'b0;
        bus.lsb_addr = 32'h2000;
        bus.lsb_len  = 2'd3;
        tick();
        tick();
        tick();
        bus.rdy_in = 1'b0;
        #1;
        vectors++;
        if (bus.mem_wr !== 1'b0 || bus.mem_a !== 32'h2002) begin
            miscompares++;
            $display("FAIL rdyr_freeze got wr=%b a=%h want 0 00002002", bus.mem_wr, bus.mem_a);
        end
        tick();
        bus.rdy_in = 1'b1;
        #1;
        // Rolled back: byte 1 is requested again, then the sequence resumes.
        for (int i = 0; i < 4; i++) begin
            exp_a = (i == 3) ? 32'd0 : 32'h2001 + 32'(i);
            vectors++;
            if (bus.mem_a !== exp_a || bus.lsb_done !== 1'b0) begin
                miscompares++;
                $display("FAIL rdyr_seq[%0d] got a=%h lsd=%b want %h 0", i, bus.mem_a, bus.lsb_done, exp_a);
            end
            tick();
        end
        vectors++;
        if (bus.lsb_done !== 1'b1 || bus.lsb_rdata !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL rdyr_done got lsd=%b rdata=%h want 1 12345678", bus.lsb_done, bus.lsb_rdata);
        end
        bus.lsb_req = 1'b0;
        tick();
    endtask

    task automatic test_wrap_reset;
        bus.lsb_req  = 1'b1;
        bus.lsb_wr   = 1'b0;
        bus.lsb_addr = 32'hFFFF_FFFF;
        bus.lsb_len  = 2'd1;
        tick();
        vectors++;
        if (bus.mem_a !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL wrap_a0 got a=%h want ffffffff", bus.mem_a);
        end
        tick();
        vectors++;
        if (bus.mem_a !== 32'd0) begin
            miscompares++;
            $display("FAIL wrap_a1 got a=%h want 0", bus.mem_a);
        end
        tick();
        tick();
        vectors++;
        if (bus.lsb_done !== 1'b1 || bus.lsb_rdata !== 32'h0000_3CC3) begin
            miscompares++;
            $display("FAIL wrap_done got lsd=%b rdata=%h want 1 00003cc3", bus.lsb_done, bus.lsb_rdata);
        end
        bus.lsb_req = 1'b0;
        tick();
        bus.lsb_req  = 1'b1;
        bus.lsb_addr = 32'h2000;
        bus.lsb_len  = 2'd2;
        tick();
        tick();
        rst_in = 1'b1;
        #1;
        vectors++;
        if (bus.mem_a !== 32'd0 || bus.mem_wr !== 1'b0 || bus.mem_dout !== 8'd0 ||
            bus.lsb_done !== 1'b0 || bus.lsb_rdata !== 32'd0 || bus.if_done !== 1'b0 || bus.if_data !== 32'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs got a=%h wr=%b dout=%h lsd=%b rdata=%h want all 0",
                     bus.mem_a, bus.mem_wr, bus.mem_dout, bus.lsb_done, bus.lsb_rdata);
        end
        bus.lsb_req = 1'b0;
        tick();
        tick();
        rst_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if (bus.lsb_done !== 1'b0 || bus.mem_a !== 32'd0) begin
                miscompares++;
                $display("FAIL midreset_quiet[%0d] got lsd=%b a=%h want 0 0", i, bus.lsb_done, bus.mem_a);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in             = 1'b1;
        bus.rdy_in         = 1'b1;
        bus.control_hazard = 1'b0;
        bus.if_req         = 1'b0;
        bus.if_addr        = 32'd0;
        bus.lsb_req        = 1'b0;
        bus.lsb_wr         = 1'b0;
        bus.lsb_addr       = 32'd0;
        bus.lsb_len        = 2'd0;
        bus.lsb_wdata      = 32'd0;
        bus.io_buffer_full = 1'b0;
        test_reset();
        test_fetch();
        test_priority();
        test_io_stall();
        test_hazard();
        test_rdy_write();
        test_rdy_read();
        test_wrap_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
